// File: rtl/shift_left_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shift_left_pipe_pkg
// Shared constants, stage payload type and the per-stage shift helper for the
// five-stage pipelined logical left shifter (shift_left_pipe).
// Optional feature macro: SHIFT_LEFT_ROTATE_EN (rotate-left instead of
// zero-fill when the operation's rot flag is set).
// -----------------------------------------------------------------------------
package shift_left_pipe_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   // Payload carried from stage to stage. The tag travels beside this struct
   // because its width is a parameter of the block, not a package constant.
   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [SHAMT_W-1:0] amt;
      logic               rot;
   } stage_payload_t;

   // One fixed-distance step: shift left by sh, refilling the low bits with
   // either zeros or the bits that left the top (rotate).
   function automatic logic [DATA_W-1:0] shl_step(
      input logic [DATA_W-1:0] d,
      input int unsigned       sh,
      input logic              rot
   );
      logic [DATA_W-1:0] fill;
      if (rot) begin
         fill = d >> (DATA_W - sh);
      end else begin
         fill = {DATA_W{1'b0}};
      end
      return (d << sh) | fill;
   endfunction

endpackage

// File: rtl/shift_left_stage.sv
// -----------------------------------------------------------------------------
// shift_left_stage
// One elastic register slice of the left-shift pipeline. On load it applies a
// shift of SHIFT positions if the matching bit of the shift amount is set.
// Optional feature macro: SHIFT_LEFT_ROTATE_EN (honour payload rot flag).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous kill of the held operation
//   up_valid_i      upstream offers an operation
//   up_payload_i    upstream data/amount/rot
//   up_tag_i        upstream sideband tag
//   up_ready_o      this slice can take an operation this cycle
//   dn_valid_o      slice holds an operation (registered)
//   dn_payload_o    held payload (registered)
//   dn_tag_o        held tag (registered)
//   dn_ready_i      downstream takes the held operation this cycle
// -----------------------------------------------------------------------------
module shift_left_stage
   import shift_left_pipe_pkg::*;
#(
   parameter int SHIFT = 1,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             up_valid_i,
   input  stage_payload_t   up_payload_i,
   input  logic [TAG_W-1:0] up_tag_i,
   output logic             up_ready_o,
   output logic             dn_valid_o,
   output stage_payload_t   dn_payload_o,
   output logic [TAG_W-1:0] dn_tag_o,
   input  logic             dn_ready_i
);

   // Amount bit resolved by this slice: 16->4, 8->3, 4->2, 2->1, 1->0.
   localparam int AMT_BIT = $clog2(SHIFT);

   logic             valid_q, valid_d;
   stage_payload_t   payload_q, payload_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             do_rot_s;

`ifdef SHIFT_LEFT_ROTATE_EN
   assign do_rot_s = up_payload_i.rot;
`else
   assign do_rot_s = 1'b0;
`endif

   // An empty slice, or one whose content leaves this cycle, can accept.
   assign up_ready_o   = !valid_q || dn_ready_i;
   assign dn_valid_o   = valid_q;
   assign dn_payload_o = payload_q;
   assign dn_tag_o     = tag_q;

   // Next-state: valid follows the handshake, payload loads only on accept.
   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      tag_d     = tag_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (up_ready_o) begin
         valid_d = up_valid_i;
      end else begin
         valid_d = valid_q;
      end
      if (up_ready_o && up_valid_i) begin
         if (up_payload_i.amt[AMT_BIT]) begin
            payload_d.data = shl_step(up_payload_i.data, SHIFT, do_rot_s);
         end else begin
            payload_d.data = up_payload_i.data;
         end
         payload_d.amt = up_payload_i.amt;
         payload_d.rot = up_payload_i.rot;
         tag_d         = up_tag_i;
      end else begin
         payload_d = payload_q;
         tag_d     = tag_q;
      end
   end

   // Slice registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         tag_q     <= {TAG_W{1'b0}};
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
         tag_q     <= tag_d;
      end
   end

endmodule

// File: rtl/shift_left_pipe.sv
// -----------------------------------------------------------------------------
// shift_left_pipe
// Five-stage pipelined 32-bit logical left shifter with valid/ready on both
// sides. Stages shift by 16, 8, 4, 2, 1; results leave straight from the last
// stage's registers. A tag rides along with each operation.
// Optional feature macro: SHIFT_LEFT_ROTATE_EN adds in_rot (rotate-left).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                kill all in-flight operations (and the one offered)
//   in_valid/in_ready    input handshake (in_ready combinational on out_ready)
//   data_in, shift_amt   operand and shift distance 0..31
//   in_tag               sideband tag
//   in_rot               rotate instead of zero-fill (macro builds only)
//   out_valid/out_ready  output handshake
//   data_out, out_tag    result and its tag
// -----------------------------------------------------------------------------
module shift_left_pipe
   import shift_left_pipe_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  data_in,
   input  logic [SHAMT_W-1:0] shift_amt,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef SHIFT_LEFT_ROTATE_EN
   input  logic               in_rot,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  data_out,
   output logic [TAG_W-1:0]   out_tag
);

   // Index k is the boundary in front of stage k+1; index 5 is the output.
   logic             valid_s   [0:5];
   stage_payload_t   payload_s [0:5];
   logic [TAG_W-1:0] tag_s     [0:5];
   logic             ready_s   [0:5];
   stage_payload_t   in_payload_s;
   logic             unused_s;

   // Pack the offered operation into the stage payload.
   always_comb begin
      in_payload_s.data = data_in;
      in_payload_s.amt  = shift_amt;
`ifdef SHIFT_LEFT_ROTATE_EN
      in_payload_s.rot  = in_rot;
`else
      in_payload_s.rot  = 1'b0;
`endif
   end

   assign valid_s[0]   = in_valid;
   assign payload_s[0] = in_payload_s;
   assign tag_s[0]     = in_tag;
   assign ready_s[5]   = out_ready;

   for (genvar k = 0; k < 5; k++) begin : g_stage
      shift_left_stage #(
         .SHIFT (16 >> k),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk          (clk),
         .rst          (rst),
         .flush        (flush),
         .up_valid_i   (valid_s[k]),
         .up_payload_i (payload_s[k]),
         .up_tag_i     (tag_s[k]),
         .up_ready_o   (ready_s[k]),
         .dn_valid_o   (valid_s[k+1]),
         .dn_payload_o (payload_s[k+1]),
         .dn_tag_o     (tag_s[k+1]),
         .dn_ready_i   (ready_s[k+1])
      );
   end

   assign in_ready  = ready_s[0];
   assign out_valid = valid_s[5];
   assign data_out  = payload_s[5].data;
   assign out_tag   = tag_s[5];

   // Amount and rot are fully consumed by the time they reach the output.
   assign unused_s = ^{payload_s[5].amt, payload_s[5].rot};

endmodule

// File: tb/tb_shift_left_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_left_pipe
// Scoreboard bench: the driver records the expected result on every accepted
// input; a negedge monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_shift_left_pipe;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      data_in = 32'd0;
   logic [4:0]       shift_amt = 5'd0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             in_rot = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      data_out;
   logic [TAG_W-1:0] out_tag;

   shift_left_pipe #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .shift_amt (shift_amt),
      .in_tag    (in_tag),
`ifdef SHIFT_LEFT_ROTATE_EN
      .in_rot    (in_rot),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      d;
      logic [TAG_W-1:0] t;
      int               c;
      bit               lat;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] exp_d = 32'd0;
   bit          lat_chk = 1'b0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: output transfer pops first, then flush clears or an accept pushes.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_out: got data 0x%08h tag %0d, expected no result", data_out, out_tag);
            end else begin
               mon_e = sbq.pop_front();
               chk("data_out", 64'(data_out), 64'(mon_e.d));
               chk("out_tag", 64'(out_tag), 64'(mon_e.t));
               if (mon_e.lat) chk("latency", 64'(cyc - mon_e.c), 64'd5);
            end
         end
         if (flush) begin
            sbq.delete();
         end else if (in_valid && in_ready) begin
            sbq.push_back('{exp_d, in_tag, cyc, lat_chk});
            n_acc++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [TAG_W-1:0] t,
                       input logic r, input logic [31:0] e);
      int w;
      data_in = d; shift_amt = a; in_tag = t; in_rot = r; exp_d = e; in_valid = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!in_ready && w < 50);
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1", w);
      end
      @(posedge clk);
      #2 in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int w;
      w = 0;
      while (sbq.size() != 0 && w < bound) begin
         @(posedge clk);
         w++;
      end
      #2;
      chk("drain_pending", 64'(sbq.size()), 64'd0);
      sbq.delete();
   endtask

   logic [31:0] bp_exp [0:9] = '{32'h3, 32'h6, 32'hC, 32'h18, 32'h30,
                                 32'h60, 32'hC0, 32'h180, 32'h300, 32'h600};

   initial begin
      int acc0;
      #1 rst = 1'b1;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_data_out", 64'(data_out), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      tick(2);
      rst = 1'b0;
      tick(1);

      // Single operations, boundary amounts.
      lat_chk = 1'b1;
      send(32'h0000_0001, 5'd31, 5'd7, 1'b0, 32'h8000_0000);
      wait_drain(20);
      send(32'hDEAD_BEEF, 5'd0, 5'd3, 1'b0, 32'hDEAD_BEEF);
      send(32'h1234_5678, 5'd4, 5'd1, 1'b0, 32'h2345_6780);
      send(32'hA5A5_A5A5, 5'd16, 5'd2, 1'b0, 32'hA5A5_0000);
      send(32'hFFFF_FFFF, 5'd27, 5'd4, 1'b0, 32'hF800_0000);
      wait_drain(20);

      // Streaming back-to-back, every amount.
      for (int n = 0; n < 32; n++) begin
         send(32'hFFFF_FFFF, 5'(n), TAG_W'(n), 1'b0, 32'hFFFF_FFFF << n);
      end
      wait_drain(50);

      // Back-pressure: exactly five operations fit.
      lat_chk = 1'b0;
      out_ready = 1'b0;
      acc0 = n_acc;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = 32'h3; shift_amt = 5'(i); in_tag = TAG_W'(i + 10); exp_d = bp_exp[i];
         tick(1);
      end
      chk("bp_accepted", 64'(n_acc - acc0), 64'd5);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_head_data", 64'(data_out), 64'h3);
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain(20);

      // Flush with four in flight plus one offered.
      lat_chk = 1'b1;
      send(32'h1, 5'd1, 5'd20, 1'b0, 32'h2);
      send(32'h1, 5'd2, 5'd21, 1'b0, 32'h4);
      send(32'h1, 5'd3, 5'd22, 1'b0, 32'h8);
      send(32'h1, 5'd4, 5'd23, 1'b0, 32'h10);
      flush = 1'b1; in_valid = 1'b1;
      data_in = 32'hFFFF; shift_amt = 5'd0; in_tag = 5'd24; exp_d = 32'hFFFF;
      tick(1);
      flush = 1'b0; in_valid = 1'b0;
      tick(10);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      send(32'h0F0F_0F0F, 5'd8, 5'd25, 1'b0, 32'h0F0F_0F00);
      wait_drain(20);

      // Asynchronous reset with three in flight.
      send(32'h11, 5'd1, 5'd26, 1'b0, 32'h22);
      send(32'h11, 5'd2, 5'd27, 1'b0, 32'h44);
      send(32'h11, 5'd3, 5'd28, 1'b0, 32'h88);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data_out", 64'(data_out), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      sbq.delete();
      tick(2);
      rst = 1'b0;
      tick(10);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      send(32'h8000_0001, 5'd4, 5'd9, 1'b0, 32'h0000_0010);
`ifdef SHIFT_LEFT_ROTATE_EN
      send(32'h8000_0001, 5'd4, 5'd10, 1'b1, 32'h0000_0018);
      send(32'hF000_000F, 5'd31, 5'd11, 1'b1, 32'hF800_0007);
`endif
      wait_drain(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
